// File: rtl/spmv_loader_if.sv
// spmv_loader_if: upstream beat stream (dense-vector and COO weight entries) into the loader
interface spmv_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic       s_type;
  logic       s_last;
  logic [4:0] s_row;
  logic [4:0] s_col;
  logic [7:0] s_data;
  modport master (output s_valid, s_type, s_row, s_col, s_data, s_last, input s_ready);
  modport slave (input s_valid, s_type, s_row, s_col, s_data, s_last, output s_ready);
endinterface

// File: rtl/spmv_loader.sv
// spmv_loader: forwards vector entries, buffers a job's COO weights and replays them as one gap-free burst
module spmv_loader #(
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  spmv_loader_if.slave s,
  output logic         in_valid,
  output logic         weight_valid,
  output logic [4:0]   in_row,
  output logic [4:0]   in_col,
  output logic [7:0]   in_data,
  input  logic         spmv_finish,
  output logic         job_done,
  output logic         err_overflow,
  output logic [8:0]   burst_len
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {FILL, BURST, WAIT, FLUSH} state_t;
  state_t        state, state_n;
  logic [17:0]   mem [DEPTH];
  logic [17:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          acc, fill_acc, is_vec, full, push, pop, clr, new_job, job_start;
  assign s.s_ready = state == FILL || state == FLUSH;
  assign acc       = s.s_valid && s.s_ready;
  assign fill_acc  = acc && state == FILL;
  assign is_vec    = fill_acc && !s.s_type;
  assign full      = count == (AW+1)'(DEPTH);
  assign head      = mem[rd_ptr];
  // a job boundary: entering FILL from elsewhere, or an overflowing last beat that keeps us in FILL
  assign new_job   = (state != FILL && state_n == FILL) || (state == FILL && clr);
  always_comb begin
    state_n = state;
    push = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
    case (state)
      FILL: if (fill_acc && s.s_type) begin
        push = !full;
        clr = full;
        state_n = full ? (s.s_last ? FILL : FLUSH) : (s.s_last ? BURST : FILL);
      end
      BURST: begin
        pop = count != '0;
        state_n = count <= (AW+1)'(1) ? WAIT : BURST;
      end
      WAIT: begin
        clr = spmv_finish;
        state_n = spmv_finish ? FILL : WAIT;
      end
      FLUSH: state_n = (acc && s.s_type && s.s_last) ? FILL : FLUSH;
      default: state_n = FILL;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {s.s_row, s.s_col, s.s_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_valid     <= 1'b0;
      weight_valid <= 1'b0;
      in_row       <= '0;
      in_col       <= '0;
      in_data      <= '0;
      job_done     <= 1'b0;
      err_overflow <= 1'b0;
      burst_len    <= '0;
      job_start    <= 1'b1;
    end else begin
      state        <= state_n;
      wr_ptr       <= clr ? '0 : wr_ptr + AW'(push);
      rd_ptr       <= clr ? '0 : rd_ptr + AW'(pop);
      count        <= clr ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      in_valid     <= is_vec;
      weight_valid <= pop;
      in_row       <= pop ? head[17:13] : is_vec ? s.s_row : '0;
      in_col       <= pop ? head[12:8] : '0;
      in_data      <= pop ? head[7:0] : is_vec ? s.s_data : '0;
      job_done     <= state == WAIT && spmv_finish;
      burst_len    <= (push && s.s_last) ? 9'(count) + 9'd1 : burst_len;
      err_overflow <= (fill_acc && s.s_type && full) ? 1'b1 : (fill_acc && job_start) ? 1'b0 : err_overflow;
      job_start    <= new_job ? 1'b1 : fill_acc ? 1'b0 : job_start;
    end
  end
endmodule
